muldiv_ctrl: RTL
================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer for the shared multiplier and iterative divider behind the EX stage.
//  Latches operands when a MUL/MULT/MULTU/DIV/DIVU sits in EX and drives the
//  external mul/div units. Raises stall_req until the result is ready, then holds
//  HI/LO (or the GPR result for MUL) until EX advances. Annuls on exception flush.
// PARAMETERS
//  MUL_LAT   2   cycles from stable mul_a/mul_b to valid mul_result (>=1)
//  CNT_W     2   width of mul latency counter; must hold MUL_LAT-1
// PORTS
//  clk           in   1   clock
//  resetn        in   1   reset; one clock, asynchronous assert, active-low
//  req_valid     in   1   EX holds a mul/div instruction (held stable while stalled)
//  req_op        in   5   one-hot {mul,mult,multu,div,divu}
//  src_a         in   32  rs value
//  src_b         in   32  rt value
//  ex_allowout   in   1   EX advances this cycle (no other stall source)
//  flush         in   1   exception flush; annul the current operation
//  stall_req     out  1   stall EX until result is ready
//  res_valid     out  1   res_hi/res_lo valid (state DONE)
//  res_hi        out  32  HI result: product[63:32] or remainder
//  res_lo        out  32  LO result: product[31:0] or quotient; GPR value for MUL
//  hilo_we       out  1   res_valid & op!=mul
//  res_to_gpr    out  1   res_valid & op==mul
//  mul_signed    out  1   to mul unit
//  mul_a, mul_b  out  32  to mul unit; registered operands
//  mul_result    in   64  from mul unit
//  div_start     out  1   to divider; held high until div_ready
//  div_signed    out  1   to divider
//  div_a, div_b  out  32  to divider; registered operands
//  div_annul     out  1   to divider; one-cycle abort pulse
//  div_result    in   64  {remainder,quotient}
//  div_ready     in   1   divider result valid (single-cycle pulse)
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, operand/result regs 0, all outputs 0.
//  - States IDLE, MUL_WAIT, DIV_WAIT, DONE (2-bit encoding).
//  - stall_req = req_valid & ~flush & state!=DONE. Combinational, so it is high
//    in the issue cycle.
//  - IDLE, req_valid & ~flush: latch src_a/src_b/req_op, then
//    - mul class -> MUL_WAIT, cnt=0.
//    - div/divu with src_b==0 -> DONE, res_hi=src_a, res_lo=32'hFFFF_FFFF. No div_start.
//    - other div -> DIV_WAIT.
//  - MUL_WAIT: cnt++ each cycle. When cnt==MUL_LAT-1, capture mul_result -> DONE.
//    Total stall = MUL_LAT+1 cycles.
//  - DIV_WAIT: div_start=1 and div_signed per op. On div_ready: capture
//    res_hi=div_result[63:32], res_lo=div_result[31:0] -> DONE. div_start is 0 in DONE.
//  - DONE: res_valid=1. Result regs frozen; req_valid is ignored (no restart).
//    Leave to IDLE when ex_allowout=1.
//  - flush in any state -> IDLE next cycle, results discarded, res_valid 0.
//    div_annul=1 that cycle if state==DIV_WAIT. flush beats div_ready, counter
//    completion and ex_allowout in the same cycle.
//  - req_valid falls in MUL_WAIT/DIV_WAIT without flush: treated as flush (annul, IDLE).
//  - req_op not one-hot while req_valid: illegal. Simulation assertion fires; no RTL recovery.
//  - Signedness: mult/mul/div are signed, multu/divu unsigned. Operands are never
//    re-sampled after issue.
//  - Reset during operation: immediate return to IDLE, outputs 0. The divider sees
//    the same reset.
// STRUCTURE
//  - defines.vh: state encodings, MD_OP_* one-hot indices, DivStart/DivStop,
//    DivResultReady/NotReady, Stop/NoStop.
//  - Single module, no sub-module. The mul latency counter is inline.
// TESTING
//  1 multu 0xFFFF_FFFF*2, MUL_LAT=2 -> stall 3 cycles; hi=1, lo=0xFFFF_FFFE,
//    hilo_we=1.
//  2 div -7/2, divider model ready after 33 cycles -> hi=0xFFFF_FFFF,
//    lo=0xFFFF_FFFD; stall drops the cycle after div_ready.
//  3 divu 5/0 -> DONE after 1 cycle, div_start never high; hi=5, lo=0xFFFF_FFFF.
//  4 div, flush on DIV_WAIT cycle 10 -> div_annul 1-cycle pulse, IDLE, res_valid
//    stays 0, a new req issues cleanly.
//  5 mul 3*-4 then ex_allowout=0 for 3 cycles -> lo=0xFFFF_FFF4, res_to_gpr=1 held,
//    stall_req 0, no mul/div restart.
//  6 resetn low mid-DIV_WAIT -> all outputs 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and op-field helpers for the EX-stage multiply/divide sequencer.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } md_state_e;

    // Bit positions inside req_op = {mul, mult, multu, div, divu}
    localparam int MD_OP_MUL   = 4;
    localparam int MD_OP_MULT  = 3;
    localparam int MD_OP_MULTU = 2;
    localparam int MD_OP_DIV   = 1;

    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    function automatic logic op_is_mul_class(input logic [4:0] op);
        return op[MD_OP_MUL] | op[MD_OP_MULT] | op[MD_OP_MULTU];
    endfunction

    function automatic logic op_is_signed(input logic [4:0] op);
        return op[MD_OP_MUL] | op[MD_OP_MULT] | op[MD_OP_DIV];
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multiplier and iterative divider behind EX: latches
// operands, drives the units, stalls EX until the result is ready, holds it until EX advances.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | no operation in flight; issues on req_valid & ~flush
// MUL_WAIT  | waiting MUL_LAT cycles for mul_result to settle
// DIV_WAIT  | div_start held high until the divider pulses div_ready
// DONE      | result held on res_hi/res_lo until ex_allowout
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [4:0]  req_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        ex_allowout,
    input  logic        flush,
    output logic        stall_req,
    output logic        res_valid,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        hilo_we,
    output logic        res_to_gpr,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready
);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic             gpr_q, gpr_d;
    logic             mul_sgn_q, mul_sgn_d;
    logic             div_sgn_q, div_sgn_d;
    logic             abort;

    // A dropped req_valid while waiting means EX lost the instruction: same as flush.
    assign abort = flush | ~req_valid;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        gpr_d     = gpr_q;
        mul_sgn_d = mul_sgn_q;
        div_sgn_d = div_sgn_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    a_d       = src_a;
                    b_d       = src_b;
                    cnt_d     = '0;
                    gpr_d     = req_op[MD_OP_MUL];
                    mul_sgn_d = op_is_mul_class(req_op) & op_is_signed(req_op);
                    div_sgn_d = req_op[MD_OP_DIV];
                    if (op_is_mul_class(req_op)) begin
                        state_d = ST_MUL_WAIT;
                    end else if (src_b == '0) begin
                        hi_d    = src_a;
                        lo_d    = DIV_ZERO_QUOT;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DIV_WAIT;
                    end
                end
            end
            ST_MUL_WAIT: begin
                if (abort) begin
                    hi_d    = '0;
                    lo_d    = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    hi_d    = mul_result[63:32];
                    lo_d    = mul_result[31:0];
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DIV_WAIT: begin
                if (abort) begin
                    hi_d    = '0;
                    lo_d    = '0;
                    state_d = ST_IDLE;
                end else if (div_ready) begin
                    hi_d    = div_result[63:32];
                    lo_d    = div_result[31:0];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush) begin
                    hi_d    = '0;
                    lo_d    = '0;
                    state_d = ST_IDLE;
                end else if (ex_allowout) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            gpr_q     <= 1'b0;
            mul_sgn_q <= 1'b0;
            div_sgn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            gpr_q     <= gpr_d;
            mul_sgn_q <= mul_sgn_d;
            div_sgn_q <= div_sgn_d;
        end
    end

    // Gated by resetn so the stall also drops while reset is held with req_valid high.
    assign stall_req  = resetn & req_valid & ~flush & (state_q != ST_DONE);
    assign res_valid  = (state_q == ST_DONE);
    assign res_hi     = hi_q;
    assign res_lo     = lo_q;
    assign hilo_we    = res_valid & ~gpr_q;
    assign res_to_gpr = res_valid & gpr_q;
    assign mul_signed = mul_sgn_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign div_start  = (state_q == ST_DIV_WAIT);
    assign div_signed = div_sgn_q;
    assign div_a      = a_q;
    assign div_b      = b_q;
    assign div_annul  = (state_q == ST_DIV_WAIT) & abort;

    a_op_onehot: assert property (@(posedge clk) disable iff (!resetn)
        req_valid |-> $onehot(req_op));

endmodule
